hangy_input_frontend: RTL and testbench
=======================================

// Module: hangy_input_frontend
// PURPOSE
//   Conditions the raw game pins before they reach the hangman game core.
//   Synchronises all 12 input pins and debounces the NEXT button. Every clean press becomes a
//   single-cycle NEXT pulse, with the character and word index captured and held stable around it.
//   Output uses the core's input format: {word_idx[5:0], next, char[4:0]}. Sits between io_in and the core.
// PARAMETERS
//   DEBOUNCE_CYCLES  16     consecutive stable cycles required to accept a button level change (>=2)
//   LFSR_SEED        6'h2D  reset value of the word-index LFSR; a zero value is replaced by 6'h01
//   MAX_CHAR         5'd25  highest legal character code (A..Z = 0..25)
// PORTS
//   clk           in   1   system clock (wb_clk_i at top level)
//   rst_n         in   1   asynchronous, active-low reset
//   pin_in        in   12  raw pins: [11:6] word index, [5] NEXT button, [4:0] character
//   chip_input    out  12  to game core: [11:6] captured index, [5] next pulse, [4:0] captured char
//   char_invalid  out  1   captured char > MAX_CHAR; informational only
// BEHAVIOUR
//   Reset (async assert, sync release): sync flops, debounced level, counter, captured fields,
//     chip_input and char_invalid all 0; FSM in FE_IDLE; LFSR = LFSR_SEED.
//   Sync: 2-flop synchroniser on all 12 bits; the logic below uses only the synchronised copy.
//   Debounce: btn_q is the accepted level. cnt is cleared when sync[5]==btn_q.
//     While they differ, cnt increments. When cnt==DEBOUNCE_CYCLES-1 and they still differ,
//     btn_q flips and cnt clears. A pin transition is therefore accepted at edge DEBOUNCE_CYCLES+2.
//   FSM, fe_state_t:
//     FE_IDLE  : next=0. On btn_q==1: capture char, index and char_invalid, then go to FE_SETUP.
//     FE_SETUP : next=0, data held stable for one cycle, then go to FE_PULSE.
//     FE_PULSE : next=1 for exactly one cycle, then go to FE_HOLD.
//     FE_HOLD  : next=0, data held. Go to FE_IDLE only after btn_q==0.
//   Latency: next rises DEBOUNCE_CYCLES+4 edges after the pin rises. The pulse is always 1 cycle.
//   chip_input[4:0] and [11:6] change only on capture, never during FE_SETUP, FE_PULSE or FE_HOLD.
//   Boundaries:
//     - Bounce shorter than DEBOUNCE_CYCLES: ignored.
//     - Button held indefinitely: one pulse only. A re-press needs a debounced release first.
//     - Press already debounced at reset release: a pulse is issued (btn_q starts at 0).
//     - Invalid char: still captured and forwarded with a pulse; char_invalid=1 until the next capture.
//     - Reset mid-sequence: immediate return to the reset state; any pending pulse is lost.
//     - Character and index pins are sampled only at capture; their changes at other times are ignored.
// CONFIGURATION
//   RANDOM_WORD_EN defined:
//     - 6-bit Fibonacci LFSR (x^6+x^5+1) steps every cycle; period 63; never 0.
//     - Capture takes chip_input[11:6] from the LFSR value instead of pin_in[11:6].
//     - pin_in[11:6] is unused.
//   RANDOM_WORD_EN undefined: no LFSR is built; the index comes from pin_in[11:6].
// STRUCTURE
//   hangy_pkg:
//     - fe_state_t enum {FE_IDLE, FE_SETUP, FE_PULSE, FE_HOLD}
//     - FE_MAX_CHAR constant
//     - FE_LFSR_TAPS = 6'b110000
//   Sub-module hangy_debouncer: synchronised level in, btn_q out; owns cnt ($clog2(DEBOUNCE_CYCLES) bits).
//   Top: synchroniser, capture registers, FSM, optional LFSR.
// TESTING
//   1 Reset: rst_n=0 mid-run, pins toggling -> chip_input=12'h000 and char_invalid=0 immediately;
//     FSM in FE_IDLE.
//   2 Clean press: pin_in[4:0]=7, [11:6]=12, [5] high 40 cycles (D=16) -> chip_input=12'h307
//     before the pulse; a single next=1 at edge 20; [11:6]=12 and [4:0]=7 held until the next press.
//   3 Bounce and glitch:
//     - [5] high 10 cycles, then low -> no pulse.
//     - [5] toggling every 3 cycles for 30 cycles, then high 40 -> exactly one pulse.
//   4 Hold and re-press: [5] high 200 cycles -> one pulse. Then low 20, then high 40 with char 3 ->
//     second pulse, chip_input[4:0]=3.
//   5 Invalid char: char 30 pressed -> pulse issued, chip_input[4:0]=30, char_invalid=1.
//     Next press with char 2 -> char_invalid=0.
//   6 RANDOM_WORD_EN: 64 presses -> each [11:6] equals the reference-model LFSR value at the capture
//     edge; never 0; pin_in[11:6] has no effect.

Source files
------------

// File: rtl/hangy_pkg.sv
// Shared types and constants for the hangman input front-end.
package hangy_pkg;

    localparam int unsigned FE_PIN_W   = 12;
    localparam int unsigned FE_CHAR_W  = 5;
    localparam int unsigned FE_IDX_W   = 6;
    localparam int unsigned FE_BTN_BIT = 5;

    localparam logic [FE_CHAR_W-1:0] FE_MAX_CHAR  = 5'd25;
    localparam logic [FE_IDX_W-1:0]  FE_LFSR_TAPS = 6'b110000;
    localparam logic [FE_IDX_W-1:0]  FE_LFSR_SEED = 6'h2D;

    typedef enum logic [1:0] {
        FE_IDLE,
        FE_SETUP,
        FE_PULSE,
        FE_HOLD
    } fe_state_t;

    // Core input word layout: {word_idx, next, char}
    typedef struct packed {
        logic [FE_IDX_W-1:0]  word_idx;
        logic                 next;
        logic [FE_CHAR_W-1:0] chr;
    } fe_core_in_t;

    // One Fibonacci step of x^6+x^5+1
    function automatic logic [FE_IDX_W-1:0] fe_lfsr_step(input logic [FE_IDX_W-1:0] s);
        return {s[FE_IDX_W-2:0], ^(s & FE_LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/hangy_input_frontend_if.sv
// Pin-side / core-side bundle of the hangman input front-end.
interface hangy_fe_if;
    import hangy_pkg::*;

    logic [FE_PIN_W-1:0] pin_in;
    logic [FE_PIN_W-1:0] chip_input;
    logic                char_invalid;

    modport master (output pin_in, input chip_input, input char_invalid);
    modport slave  (input pin_in, output chip_input, output char_invalid);
endinterface

// File: rtl/hangy_debouncer.sv
// Accepts a level change only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module hangy_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic btn_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_q, btn_d;

    always_comb begin
        cnt_d = cnt_q;
        btn_d = btn_q;
        if (level_i == btn_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            btn_d = level_i;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            btn_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            btn_q <= btn_d;
        end
    end

    assign btn_o = btn_q;

endmodule

// File: rtl/hangy_input_frontend.sv
// Synchronises game pins, debounces NEXT and emits one framed NEXT pulse per press.
// Build option: RANDOM_WORD_EN takes the word index from an internal LFSR.
module hangy_input_frontend
    import hangy_pkg::*;
#(
    parameter int unsigned          DEBOUNCE_CYCLES = 16,
    parameter logic [FE_IDX_W-1:0]  LFSR_SEED       = FE_LFSR_SEED,
    parameter logic [FE_CHAR_W-1:0] MAX_CHAR        = FE_MAX_CHAR
) (
    input  logic     clk,
    input  logic     rst_n,
    hangy_fe_if.slave fe
);

    logic [FE_PIN_W-1:0] sync1_q, sync2_q;
    logic                btn_q;
    logic [FE_IDX_W-1:0] idx_src;

    fe_state_t   state_q, state_d;
    fe_core_in_t out_q, out_d;
    logic        inv_q, inv_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= fe.pin_in;
            sync2_q <= sync1_q;
        end
    end

    hangy_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (sync2_q[FE_BTN_BIT]),
        .btn_o   (btn_q)
    );

`ifdef RANDOM_WORD_EN
    // All-zero seed would lock the LFSR
    localparam logic [FE_IDX_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? FE_IDX_W'(1) : LFSR_SEED;

    logic [FE_IDX_W-1:0] lfsr_q;
    logic [FE_IDX_W-1:0] unused_pin_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED_EFF;
        else        lfsr_q <= fe_lfsr_step(lfsr_q);
    end

    assign idx_src        = lfsr_q;
    assign unused_pin_idx = sync2_q[FE_PIN_W-1:FE_CHAR_W+1];
`else
    logic [FE_IDX_W-1:0] unused_seed;

    assign idx_src     = sync2_q[FE_PIN_W-1:FE_CHAR_W+1];
    assign unused_seed = LFSR_SEED;
`endif

    // Capture on accepted press, one setup cycle, one pulse cycle, hold until release
    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        out_d.next = 1'b0;
        inv_d      = inv_q;
        case (state_q)
            FE_IDLE: begin
                if (btn_q) begin
                    out_d.chr      = sync2_q[FE_CHAR_W-1:0];
                    out_d.word_idx = idx_src;
                    inv_d          = (sync2_q[FE_CHAR_W-1:0] > MAX_CHAR);
                    state_d        = FE_SETUP;
                end
            end
            FE_SETUP: begin
                out_d.next = 1'b1;
                state_d    = FE_PULSE;
            end
            FE_PULSE: begin
                state_d = FE_HOLD;
            end
            FE_HOLD: begin
                if (!btn_q) state_d = FE_IDLE;
            end
            default: begin
                state_d = FE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FE_IDLE;
            out_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            inv_q   <= inv_d;
        end
    end

    assign fe.chip_input   = out_q;
    assign fe.char_invalid = inv_q;

endmodule

// File: tb/tb_hangy_input_frontend.sv
// Directed self-checking bench for hangy_input_frontend (DEBOUNCE_CYCLES = 16).
module tb_hangy_input_frontend;
    import hangy_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    hangy_fe_if fe ();

    hangy_input_frontend dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fe    (fe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference LFSR: m_r2 holds the value the design sampled two edges ago
    logic [5:0] m_r0, m_r1, m_r2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r0 <= 6'h2D;
            m_r1 <= 6'h00;
            m_r2 <= 6'h00;
        end else begin
            m_r0 <= {m_r0[4:0], m_r0[5] ^ m_r0[4]};
            m_r1 <= m_r0;
            m_r2 <= m_r1;
        end
    end

    function automatic logic [11:0] pins(input logic [5:0] idx, input logic btn, input logic [4:0] ch);
        return {idx, btn, ch};
    endfunction

    // Drive pins for n cycles (called at posedge+1), observing chip_input after each edge
    task automatic run_press(input logic [11:0] p, input int n, output int pulses, output int first_edge,
                             output logic [11:0] pre_data, output logic [11:0] pulse_data,
                             output logic [11:0] last_data, output logic [5:0] exp_idx);
        logic [11:0] prev;
        fe.pin_in  = p;
        pulses     = 0;
        first_edge = 0;
        pre_data   = '0;
        pulse_data = '0;
        exp_idx    = '0;
        prev       = fe.chip_input;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (fe.chip_input[5]) begin
                if (pulses == 0) begin
                    first_edge = k;
                    pre_data   = prev;
                    pulse_data = fe.chip_input;
                    exp_idx    = m_r2;
                end
                pulses++;
            end
            prev = fe.chip_input;
        end
        last_data = fe.chip_input;
    endtask

    task automatic test_reset();
        int np, fe_edge;
        logic [11:0] pre, pd, last;
        logic [5:0]  ei;
        // Press already held when reset releases
        fe.pin_in = pins(6'd5, 1'b1, 5'd4);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (fe.chip_input !== 12'h000) begin miscompares++; $display("FAIL reset_out got %h want 000", fe.chip_input); end
        rst_n = 1'b1;
        run_press(pins(6'd5, 1'b1, 5'd4), 30, np, fe_edge, pre, pd, last, ei);
        vectors++;
        if (np !== 1 || fe_edge !== 20) begin miscompares++; $display("FAIL held_at_release pulses %0d edge %0d want 1/20", np, fe_edge); end
        vectors++;
        if (pd !== 12'h164) begin miscompares++; $display("FAIL held_at_release data got %h want 164", pd); end
        run_press(pins(6'd0, 1'b0, 5'd0), 25, np, fe_edge, pre, pd, last, ei);
        // Reset while a pulse is pending (FSM in FE_SETUP)
        run_press(pins(6'd12, 1'b1, 5'd7), 19, np, fe_edge, pre, pd, last, ei);
        vectors++;
        if (last !== 12'h307 || np !== 0) begin miscompares++; $display("FAIL pre_reset_capture got %h/%0d want 307/0", last, np); end
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (fe.chip_input !== 12'h000 || fe.char_invalid !== 1'b0) begin
            miscompares++; $display("FAIL async_reset got %h/%b want 000/0", fe.chip_input, fe.char_invalid);
        end
        vectors++;
        if (dut.state_q !== FE_IDLE) begin miscompares++; $display("FAIL reset_state got %0d want FE_IDLE", dut.state_q); end
        for (int i = 0; i < 4; i++) begin
            fe.pin_in = ~fe.pin_in;
            @(posedge clk);
            #1;
            vectors++;
            if (fe.chip_input !== 12'h000) begin miscompares++; $display("FAIL in_reset_%0d got %h want 000", i, fe.chip_input); end
        end
        fe.pin_in = '0;
        rst_n = 1'b1;
        run_press(pins(6'd0, 1'b0, 5'd0), 30, np, fe_edge, pre, pd, last, ei);
        vectors++;
        if (np !== 0 || last !== 12'h000) begin miscompares++; $display("FAIL pulse_lost got %0d/%h want 0/000", np, last); end
    endtask

    task automatic test_clean_press();
        int np, fe_edge;
        logic [11:0] pre, pd, last;
        logic [5:0]  ei;
        run_press(pins(6'd12, 1'b1, 5'd7), 40, np, fe_edge, pre, pd, last, ei);
        vectors++;
        if (np !== 1 || fe_edge !== 20) begin miscompares++; $display("FAIL clean_pulse pulses %0d edge %0d want 1/20", np, fe_edge); end
        vectors++;
        if (pre !== 12'h307) begin miscompares++; $display("FAIL clean_setup got %h want 307", pre); end
        vectors++;
        if (pd !== 12'h327) begin miscompares++; $display("FAIL clean_pulse_data got %h want 327", pd); end
        // Pin data changes after capture must not reach the output
        run_press(pins(6'd40, 1'b0, 5'd20), 25, np, fe_edge, pre, pd, last, ei);
        vectors++;
        if (last !== 12'h307 || np !== 0) begin miscompares++; $display("FAIL clean_hold got %h/%0d want 307/0", last, np); end
    endtask

    task automatic test_bounce();
        int np, fe_edge, total;
        logic [11:0] pre, pd, last;
        logic [5:0]  ei;
        run_press(pins(6'd1, 1'b1, 5'd9), 10, np, fe_edge, pre, pd, last, ei);
        total = np;
        run_press(pins(6'd1, 1'b0, 5'd9), 30, np, fe_edge, pre, pd, last, ei);
        total += np;
        vectors++;
        if (total !== 0 || last !== 12'h307) begin miscompares++; $display("FAIL short_press got %0d/%h want 0/307", total, last); end
        total = 0;
        for (int s = 0; s < 10; s++) begin
            run_press(pins(6'd1, ((s % 2) == 0), 5'd9), 3, np, fe_edge, pre, pd, last, ei);
            total += np;
        end
        run_press(pins(6'd1, 1'b1, 5'd9), 40, np, fe_edge, pre, pd, last, ei);
        total += np;
        vectors++;
        if (total !== 1 || fe_edge !== 20) begin miscompares++; $display("FAIL glitch_then_press got %0d edge %0d want 1/20", total, fe_edge); end
        vectors++;
        if (pd !== 12'h069) begin miscompares++; $display("FAIL glitch_data got %h want 069", pd); end
        run_press(pins(6'd1, 1'b0, 5'd9), 25, np, fe_edge, pre, pd, last, ei);
    endtask

    task automatic test_back_to_back();
        int np, fe_edge, total;
        logic [11:0] pre, pd, last;
        logic [5:0]  ei;
        run_press(pins(6'd2, 1'b1, 5'd5), 100, np, fe_edge, pre, pd, last, ei);
        total = np;
        run_press(pins(6'd9, 1'b1, 5'd11), 100, np, fe_edge, pre, pd, last, ei);
        total += np;
        vectors++;
        if (total !== 1) begin miscompares++; $display("FAIL long_hold pulses %0d want 1", total); end
        vectors++;
        if (last !== 12'h085) begin miscompares++; $display("FAIL long_hold_data got %h want 085", last); end
        run_press(pins(6'd2, 1'b0, 5'd3), 20, np, fe_edge, pre, pd, last, ei);
        run_press(pins(6'd2, 1'b1, 5'd3), 40, np, fe_edge, pre, pd, last, ei);
        vectors++;
        if (np !== 1 || fe_edge !== 20 || pd[4:0] !== 5'd3) begin
            miscompares++; $display("FAIL repress got %0d edge %0d char %0d want 1/20/3", np, fe_edge, pd[4:0]);
        end
        run_press(pins(6'd2, 1'b0, 5'd3), 25, np, fe_edge, pre, pd, last, ei);
    endtask

    task automatic test_invalid_char();
        int np, fe_edge;
        logic [11:0] pre, pd, last;
        logic [5:0]  ei;
        logic [4:0]  chars [4];
        logic        want  [4];
        chars = '{5'd30, 5'd2, 5'd25, 5'd26};
        want  = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_press(pins(6'd3, 1'b1, chars[i]), 40, np, fe_edge, pre, pd, last, ei);
            vectors++;
            if (np !== 1 || last[4:0] !== chars[i] || fe.char_invalid !== want[i]) begin
                miscompares++;
                $display("FAIL char_%0d got %0d/%0d/%b want 1/%0d/%b", i, np, last[4:0], fe.char_invalid, chars[i], want[i]);
            end
            run_press(pins(6'd3, 1'b0, 5'd0), 25, np, fe_edge, pre, pd, last, ei);
            vectors++;
            if (fe.char_invalid !== want[i]) begin
                miscompares++; $display("FAIL char_inv_hold_%0d got %b want %b", i, fe.char_invalid, want[i]);
            end
        end
    endtask

`ifdef RANDOM_WORD_EN
    task automatic test_random_word();
        int np, fe_edge;
        logic [11:0] pre, pd, last;
        logic [5:0]  ei;
        for (int i = 0; i < 64; i++) begin
            run_press(pins(6'($urandom), 1'b1, 5'd1), 40, np, fe_edge, pre, pd, last, ei);
            vectors++;
            if (np !== 1 || pd[11:6] !== ei || pd[11:6] === 6'd0) begin
                miscompares++; $display("FAIL lfsr_%0d got %h want %h", i, pd[11:6], ei);
            end
            run_press(pins(6'($urandom), 1'b0, 5'd1), 22, np, fe_edge, pre, pd, last, ei);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        fe.pin_in   = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_back_to_back();
        test_invalid_char();
`ifdef RANDOM_WORD_EN
        test_random_word();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
